div_ctrl: RTL and testbench

Sequencing controller for the iterative 64-bit radix-2 divider in the ALU. It accepts RISC-V M-extension divide and remainder requests (DIV/DIVU/REM/REMU and their W forms) over a valid/ready handshake. It resolves divide-by-zero and signed overflow without starting the divider, launches and tracks the divider for all other cases, and returns one 64-bit result over a valid/ready handshake. It sits between the execute-stage issue logic and the divider instance, and supports pipeline flush while a divide is in flight.

---
 rtl/div_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_div_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Desc     : Sequencing controller for the iterative 64-bit radix-2 divider.
//            Resolves divide-by-zero and signed overflow locally, launches and
//            tracks the divider otherwise, and returns one result per request.
//            Optional result-reuse cache is enabled by DIV_CTRL_REUSE_EN.
// Revision : 1.0
// ============================================================================
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_w,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        div_valid,
    output logic        div_sign,
    output logic        div_w,
    output logic [63:0] div_dividend,
    output logic [63:0] div_divisor,
    input  logic [63:0] div_quotient,
    input  logic [63:0] div_remainder,
    input  logic        div_out_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [63:0] C_MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] C_ONES  = {64{1'b1}};

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_rem;
    logic        r_div_sign;
    logic        r_div_w;
    logic [63:0] r_div_dividend;
    logic [63:0] r_div_divisor;
    logic [63:0] r_result;

    logic        w_accept;
    logic        w_signed;
    logic [63:0] w_a_eff;
    logic        w_b_zero;
    logic        w_ovf;
    logic        w_special;
    logic [63:0] w_spec_val;
    logic        w_hit;
    logic [63:0] w_hit_val;
    logic        w_fast;
    logic [63:0] w_fast_val;
    logic        w_div_done;

    function automatic logic [63:0] sext_w(input logic w, input logic [63:0] x);
        return w ? {{32{x[31]}}, x[31:0]} : x;
    endfunction

    // Classification works on the effective operands: W forms look only at
    // the low word, extended according to signedness.
    assign w_signed   = ~req_op[0];
    assign w_a_eff    = req_w ? {{32{w_signed & req_a[31]}}, req_a[31:0]} : req_a;
    assign w_b_zero   = req_w ? (req_b[31:0] == 32'd0) : (req_b == 64'd0);
    assign w_ovf      = w_signed &
                        (req_w ? ((req_a[31:0] == 32'h8000_0000) && (req_b[31:0] == 32'hFFFF_FFFF))
                               : ((req_a == C_MIN64) && (req_b == C_ONES)));
    assign w_special  = w_b_zero | w_ovf;
    assign w_spec_val = w_b_zero ? (req_op[1] ? w_a_eff : C_ONES)
                                 : (req_op[1] ? 64'd0 : w_a_eff);

    assign w_fast     = w_special | w_hit;
    assign w_fast_val = w_special ? w_spec_val : w_hit_val;

    assign w_accept   = (r_state == S_IDLE) && req_valid && !flush;
    assign w_div_done = (r_state == S_WAIT) && div_out_valid && !flush;

`ifdef DIV_CTRL_REUSE_EN
    logic        r_c_vld;
    logic        r_c_uns;
    logic        r_c_w;
    logic [63:0] r_c_a;
    logic [63:0] r_c_b;
    logic [63:0] r_c_q;
    logic [63:0] r_c_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_vld <= 1'b0;
            r_c_uns <= 1'b0;
            r_c_w   <= 1'b0;
            r_c_a   <= 64'd0;
            r_c_b   <= 64'd0;
            r_c_q   <= 64'd0;
            r_c_r   <= 64'd0;
        end else if (flush && ((r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_DRAIN))) begin
            r_c_vld <= 1'b0;
        end else if (w_div_done) begin
            r_c_vld <= 1'b1;
            r_c_uns <= ~r_div_sign;
            r_c_w   <= r_div_w;
            r_c_a   <= r_div_dividend;
            r_c_b   <= r_div_divisor;
            r_c_q   <= div_quotient;
            r_c_r   <= div_remainder;
        end
    end

    assign w_hit     = r_c_vld && (req_a == r_c_a) && (req_b == r_c_b) &&
                       (req_op[0] == r_c_uns) && (req_w == r_c_w);
    assign w_hit_val = req_op[1] ? r_c_r : r_c_q;
`else
    assign w_hit     = 1'b0;
    assign w_hit_val = 64'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        div_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = ~flush;
                if (w_accept) begin
                    w_state_nxt = w_fast ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The launch is not suppressed by flush so DRAIN always has a
                // completion pulse to wait for.
                div_valid   = 1'b1;
                w_state_nxt = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    w_state_nxt = div_out_valid ? S_IDLE : S_DRAIN;
                end else if (div_out_valid) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (flush || resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (div_out_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem          <= 1'b0;
            r_div_sign     <= 1'b0;
            r_div_w        <= 1'b0;
            r_div_dividend <= 64'd0;
            r_div_divisor  <= 64'd0;
            r_result       <= 64'd0;
        end else begin
            if (w_accept) begin
                r_rem          <= req_op[1];
                r_div_sign     <= ~req_op[0];
                r_div_w        <= req_w;
                r_div_dividend <= req_a;
                r_div_divisor  <= req_b;
                if (w_fast) begin
                    r_result <= sext_w(req_w, w_fast_val);
                end
            end
            if (w_div_done) begin
                r_result <= sext_w(r_div_w, r_rem ? div_remainder : div_quotient);
            end
        end
    end

    assign resp_data    = r_result;
    assign div_sign     = r_div_sign;
    assign div_w        = r_div_w;
    assign div_dividend = r_div_dividend;
    assign div_divisor  = r_div_divisor;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ctrl
// Desc     : Self-checking bench for div_ctrl with a 65-cycle divider model
//            and a RISC-V M-extension reference; follows DIV_CTRL_REUSE_EN.
// Revision : 1.0
// ============================================================================
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic        req_w = 1'b0;
    logic [63:0] req_a = 64'd0;
    logic [63:0] req_b = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic        div_valid;
    logic        div_sign;
    logic        div_w;
    logic [63:0] div_dividend;
    logic [63:0] div_divisor;
    logic [63:0] div_quotient = 64'd0;
    logic [63:0] div_remainder = 64'd0;
    logic        div_out_valid = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;

`ifdef DIV_CTRL_REUSE_EN
    logic        cache_ok = 1'b0;
    logic [1:0]  cache_op = 2'd0;
    logic        cache_w = 1'b0;
    logic [63:0] cache_a = 64'd0;
    logic [63:0] cache_b = 64'd0;
`endif

    div_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_w         (req_w),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .div_valid     (div_valid),
        .div_sign      (div_sign),
        .div_w         (div_w),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_out_valid (div_out_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension result for op (bit0 unsigned, bit1 remainder).
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, q32, r32, x32;
        logic [63:0] q64, r64;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32;
            end else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0;
            end else if (!op[0]) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            x32 = op[1] ? r32 : q32;
            return {{32{x32[31]}}, x32};
        end
        if (b == 64'd0) begin
            q64 = {64{1'b1}}; r64 = a;
        end else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) begin
            q64 = a; r64 = 64'd0;
        end else if (!op[0]) begin
            q64 = $signed(a) / $signed(b);
            r64 = $signed(a) % $signed(b);
        end else begin
            q64 = a / b;
            r64 = a % b;
        end
        return op[1] ? r64 : q64;
    endfunction

    function automatic logic is_special(input logic [1:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
        if (w)
            return (b[31:0] == 32'd0) ||
                   (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) ||
               (!op[0] && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}});
    endfunction

    // Divider output; the upper half of a W result is a don't-care, so fill it
    // with noise to make sure the controller sign-extends itself.
    function automatic logic [63:0] model_out(input logic rem, input logic sgn, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0] v;
        v = ref_result({rem, ~sgn}, w, a, b);
        if (w) v[63:32] = $urandom;
        return v;
    endfunction

    int dm_cnt = 0;
    logic [63:0] dm_q = 64'd0;
    logic [63:0] dm_r = 64'd0;

    always @(posedge clk) begin
        if (rst) begin
            dm_cnt        <= 0;
            div_out_valid <= 1'b0;
        end else begin
            div_out_valid <= 1'b0;
            if (div_valid) begin
                dm_cnt <= 64;
                dm_q   <= model_out(1'b0, div_sign, div_w, div_dividend, div_divisor);
                dm_r   <= model_out(1'b1, div_sign, div_w, div_dividend, div_divisor);
            end else if (dm_cnt != 0) begin
                dm_cnt <= dm_cnt - 1;
                if (dm_cnt == 1) begin
                    div_out_valid <= 1'b1;
                    div_quotient  <= dm_q;
                    div_remainder <= dm_r;
                end
            end
        end
    end

    task automatic accept(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_op = op;
        req_w = w;
        req_a = a;
        req_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 2'($urandom_range(0, 3));
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
    endtask

    task automatic do_req(input logic [1:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int hold);
        logic [63:0] exp_data, first_data;
        logic        hit, via_div;
        logic [129:0] launch_info;
        int lat, nlaunch, launch_at, held_ok;
        exp_data = ref_result(op, w, a, b);
        hit = 1'b0;
`ifdef DIV_CTRL_REUSE_EN
        hit = cache_ok && cache_a == a && cache_b == b && cache_op[0] == op[0] && cache_w == w;
`endif
        via_div = !is_special(op, w, a, b) && !hit;
        accept(op, w, a, b);
        lat = 0; nlaunch = 0; launch_at = 0; launch_info = '0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (div_valid) begin
                nlaunch++;
                launch_at = lat;
                launch_info = {div_sign, div_w, div_dividend, div_divisor};
            end
            if (resp_valid) break;
        end
        check("resp_latency", 64'(lat), via_div ? 64'd67 : 64'd1);
        check("resp_data", resp_data, exp_data);
        check("div_launches", 64'(nlaunch), {63'd0, via_div});
        if (via_div) begin
            check("launch_cycle", 64'(launch_at), 64'd1);
            check("launch_ops_lo", launch_info[63:0], b);
            check("launch_ops_hi", {62'd0, launch_info[129:128]}, {62'd0, ~op[0], w});
            check("launch_dividend", launch_info[127:64], a);
        end
        first_data = resp_data;
        held_ok = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (resp_valid && resp_data === first_data) held_ok++;
        end
        if (hold > 0) check("resp_hold", 64'(held_ok), 64'(hold));
        resp_ready = 1'b1;
        #1;
        check("req_ready_in_resp", {63'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("resp_once", {62'd0, resp_valid, busy}, 64'd0);
`ifdef DIV_CTRL_REUSE_EN
        if (via_div) begin
            cache_ok = 1'b1; cache_op = op; cache_w = w; cache_a = a; cache_b = b;
        end
`endif
    endtask

    // Flush at cycle flush_at after acceptance of DIVU a/b; the divider
    // completes at cycle 66.
    task automatic flush_in_wait(input int flush_at, input logic [63:0] a, input logic [63:0] b);
        int rv_seen, rr_bad;
        accept(2'b01, 1'b0, a, b);
        rv_seen = 0; rr_bad = 0;
        for (int n = 1; n <= 67; n++) begin
            @(negedge clk);
            flush = (n == flush_at);
            #1;
            if (resp_valid) rv_seen++;
            if (n <= 66 && req_ready) rr_bad++;
            if (n == 67) check("flush_back_idle", {62'd0, busy, req_ready}, 64'd1);
        end
        flush = 1'b0;
        check("flush_no_resp", 64'(rv_seen), 64'd0);
        check("flush_ready_low", 64'(rr_bad), 64'd0);
`ifdef DIV_CTRL_REUSE_EN
        cache_ok = 1'b0;
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  op;
        logic        w;
        logic [63:0] a, b, pa, pb;
        int sel;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_flags", {59'd0, resp_valid, div_valid, div_sign, div_w, busy}, 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_dividend", div_dividend, 64'd0);
        check("rst_divisor", div_divisor, 64'd0);
        rst = 1'b0;

        do_req(2'b01, 1'b0, 64'd100, 64'd7, 0);
        do_req(2'b11, 1'b0, 64'd100, 64'd7, 0);
        do_req(2'b00, 1'b0, -64'sd7, 64'd2, 0);
        do_req(2'b10, 1'b0, -64'sd7, 64'd2, 0);
        do_req(2'b00, 1'b0, 64'd5, 64'd0, 0);
        do_req(2'b11, 1'b0, 64'd5, 64'd0, 0);
        do_req(2'b00, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 0);
        do_req(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
        do_req(2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
        do_req(2'b01, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 5);
        check("divuw_value", ref_result(2'b01, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1),
              64'hFFFF_FFFF_FFFF_FFFE);

        flush_in_wait(12, 64'd1000, 64'd13);
        do_req(2'b01, 1'b0, 64'd9, 64'd3, 0);
        flush_in_wait(66, 64'd77, 64'd5);
        do_req(2'b01, 1'b0, 64'd77, 64'd5, 0);

        // Flush in RESP drops the result.
        accept(2'b00, 1'b0, 64'd5, 64'd0);
        @(negedge clk);
        check("fast_resp_valid", {63'd0, resp_valid}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        check("flush_resp_drop", {62'd0, resp_valid, busy}, 64'd0);
        flush = 1'b0;

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1;
        req_a = 64'd8;
        req_b = 64'd0;
        #1;
        check("flush_idle_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("flush_idle_busy", {62'd0, busy, resp_valid}, 64'd0);

        pa = 64'd100;
        pb = 64'd7;
        for (int k = 0; k < 30; k++) begin
            sel = int'($urandom_range(0, 7));
            op = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case (sel)
                0: b = w ? {$urandom, 32'd0} : 64'd0;
                1: begin
                    op[0] = 1'b0;
                    a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = w ? {$urandom, 32'hFFFF_FFFF} : {64{1'b1}};
                end
                2, 3: begin a = pa; b = pb; end
                4: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 20)); end
                5: b = 64'd0 - 64'($urandom_range(1, 9));
                default: ;
            endcase
            do_req(op, w, a, b, int'($urandom_range(0, 3)));
            pa = a;
            pb = b;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
